// File: rtl/unlock_hold_gen_if.sv
// Control/status bundle between the unlock controller and the hold generator.
// The master modport drives requests and sensor inputs; the slave modport drives actuator and status.
interface unlock_hold_gen_if #(
  parameter int CNT_W = 20
);
  logic             start;
  logic             cancel;
  logic             door_open;
  logic             unlock_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, cancel, door_open,
    input  unlock_out, busy, done, remaining
  );

  modport slave (
    input  start, cancel, door_open,
    output unlock_out, busy, done, remaining
  );
endinterface

// File: rtl/unlock_hold_gen.sv
// Timed unlock hold generator: drives the solenoid for HOLD_TIME cycles per start edge,
// optionally waits for the door to close, then enforces a lockout cooldown.
module unlock_hold_gen #(
  parameter int HOLD_TIME     = 5000,
  parameter int COOLDOWN_TIME = 1000,
  parameter int CNT_W         = 20
) (
  input  logic              clk,
  input  logic              reset,
  unlock_hold_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_CLOSE,
    S_COOLDOWN
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'((COOLDOWN_TIME > 0) ? COOLDOWN_TIME - 1 : 0);
  // With no cooldown configured, every exit path from the hold lands straight in IDLE.
  localparam state_t AFTER_HOLD = (COOLDOWN_TIME > 0) ? S_COOLDOWN : S_IDLE;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic             start_edge;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    start_d    = bus.start;
    start_edge = bus.start & ~start_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge && !bus.cancel) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end

      S_HOLD: begin
        if (bus.cancel) begin
          state_d = AFTER_HOLD;
          cnt_d   = '0;
        end else if (start_edge) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = bus.door_open ? S_WAIT_CLOSE : AFTER_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_CLOSE: begin
        if (!bus.door_open) begin
          state_d = AFTER_HOLD;
          cnt_d   = '0;
        end
      end

      S_COOLDOWN: begin
        // Start edges seen here are dropped; the edge register still tracks the input.
        if (cnt_q == COOL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // start_q resets high so a request already asserted across reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  assign bus.unlock_out = (state_q == S_HOLD);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.remaining  = (state_q == S_HOLD) ? (HOLD_LAST - cnt_q) : '0;

endmodule

// File: tb/tb_unlock_hold_gen.sv
// Bench for unlock_hold_gen: directed scenarios plus random traffic, checked every cycle
// against a countdown-based reference model of the unlock/wait/cooldown timing.
module tb_unlock_hold_gen;

  localparam int HOLD_TIME     = 8;
  localparam int COOLDOWN_TIME = 3;
  localparam int CNT_W         = 8;

  logic clk;
  logic reset;

  unlock_hold_gen_if #(.CNT_W(CNT_W)) ifc ();

  unlock_hold_gen #(
    .HOLD_TIME     (HOLD_TIME),
    .COOLDOWN_TIME (COOLDOWN_TIME),
    .CNT_W         (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: time left of unlock, waiting-for-door flag, time left of cooldown.
  int hold_left  = 0;
  bit waiting    = 0;
  int cool_left  = 0;
  bit prev_start = 1'b1;
  bit m_done     = 0;

  // Observation tallies for scenario-level checks.
  int n_unlock = 0;
  int n_done   = 0;
  int n_busy   = 0;
  logic door_lvl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit c, input bit d);
    bit edge_seen;
    edge_seen = s && !prev_start;
    prev_start = s;
    m_done = 0;
    if (r) begin
      hold_left  = 0;
      waiting    = 0;
      cool_left  = 0;
      prev_start = 1'b1;
    end else if (hold_left > 0) begin
      if (c) begin
        hold_left = 0;
        cool_left = COOLDOWN_TIME;
      end else if (edge_seen) begin
        hold_left = HOLD_TIME;
      end else if (hold_left == 1) begin
        hold_left = 0;
        m_done    = 1;
        if (d) waiting = 1;
        else   cool_left = COOLDOWN_TIME;
      end else begin
        hold_left--;
      end
    end else if (waiting) begin
      if (!d) begin
        waiting   = 0;
        cool_left = COOLDOWN_TIME;
      end
    end else if (cool_left > 0) begin
      cool_left--;
    end else if (edge_seen && !c) begin
      hold_left = HOLD_TIME;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit c, input bit d);
    reset         = r;
    ifc.start     = s;
    ifc.cancel    = c;
    ifc.door_open = d;
    @(posedge clk);
    model_edge(r, s, c, d);
    @(negedge clk);
    chk("unlock_out", 32'(ifc.unlock_out), 32'(hold_left > 0));
    chk("busy", 32'(ifc.busy), 32'(hold_left > 0 || waiting || cool_left > 0));
    chk("done", 32'(ifc.done), 32'(m_done));
    chk("remaining", 32'(ifc.remaining), (hold_left > 0) ? 32'(hold_left - 1) : 32'd0);
    n_unlock += int'(ifc.unlock_out);
    n_done   += int'(ifc.done);
    n_busy   += int'(ifc.busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, door_lvl);
  endtask

  task automatic pulse();
    step(1'b0, 1'b1, 1'b0, door_lvl);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_tally();
    n_unlock = 0;
    n_done   = 0;
    n_busy   = 0;
  endtask

  initial begin
    bit s_lvl, d_lvl;
    reset = 1'b1;
    ifc.start = 1'b0;
    ifc.cancel = 1'b0;
    ifc.door_open = 1'b0;

    // Scenario 1: basic hold, plus a start pulse in cooldown (cycle 20) that must be dropped.
    door_lvl = 1'b0;
    do_reset();
    chk("reset_unlock", 32'(ifc.unlock_out), 32'd0);
    chk("reset_busy", 32'(ifc.busy), 32'd0);
    chk("reset_remaining", 32'(ifc.remaining), 32'd0);
    clr_tally();
    idle(7); pulse(); idle(9); pulse(); idle(10);
    chk("s1_unlock_cycles", n_unlock, HOLD_TIME);
    chk("s1_done_count", n_done, 1);
    chk("s1_busy_cycles", n_busy, HOLD_TIME + COOLDOWN_TIME);

    // Scenario 2: retrigger five cycles into the hold.
    do_reset(); clr_tally();
    idle(7); pulse(); idle(4); pulse(); idle(20);
    chk("s2_unlock_cycles", n_unlock, HOLD_TIME + 5);
    chk("s2_done_count", n_done, 1);

    // Scenario 3: cancel in cycle 14, then same-cycle start+cancel in IDLE.
    do_reset(); clr_tally();
    idle(7); pulse(); idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("s3_unlock_cycles", n_unlock, 4);
    chk("s3_done_count", n_done, 0);
    chk("s3_busy_cycles", n_busy, 4 + COOLDOWN_TIME);
    clr_tally();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(12);
    chk("s3_start_cancel_unlock", n_unlock, 0);

    // Scenario 4: door held open across the hold end; start pulse inside WAIT_CLOSE ignored.
    do_reset(); clr_tally();
    idle(7); pulse(); idle(1);
    door_lvl = 1'b1;
    idle(8); pulse(); idle(4);
    door_lvl = 1'b0;
    idle(10);
    chk("s4_unlock_cycles", n_unlock, HOLD_TIME);
    chk("s4_done_count", n_done, 1);
    chk("s4_busy_cycles", n_busy, 18);

    // Scenario 5: start held through reset release does not trigger; a later pulse does.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    clr_tally();
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s5_held_unlock", n_unlock, 0);
    idle(2); pulse(); idle(14);
    chk("s5_pulse_unlock", n_unlock, HOLD_TIME);

    // Scenario 6: reset during the hold.
    do_reset(); clr_tally();
    idle(7); pulse(); idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("s6_unlock_after_reset", 32'(ifc.unlock_out), 32'd0);
    chk("s6_busy_after_reset", 32'(ifc.busy), 32'd0);
    idle(12);
    chk("s6_unlock_cycles", n_unlock, 4);
    chk("s6_done_count", n_done, 0);

    // Random traffic against the model.
    s_lvl = 1'b0;
    d_lvl = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) s_lvl = ~s_lvl;
      if ($urandom_range(0, 9) == 0) d_lvl = ~d_lvl;
      step(($urandom_range(0, 199) == 0), s_lvl, ($urandom_range(0, 15) == 0), d_lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unlock_hold_gen.md
Name: unlock_hold_gen

Overview:
- Output-side counterpart of the lock's press-and-hold detector: generates the timed unlock hold instead of measuring one.
- On a start request, drives the lock actuator (unlock_out) for exactly HOLD_TIME clk cycles.
- After the hold, the block optionally waits for the door to close, then runs a lockout cooldown. It sits between the password/control FSM and the solenoid driver pin.
- clk runs at 1 kHz, so counts are in ms; the default HOLD_TIME of 5000 is 5 s.

Parameters:
- HOLD_TIME, 5000: unlock duration in clk cycles; must be >= 1.
- COOLDOWN_TIME, 1000: lockout cycles after the hold ends; 0 means no cooldown.
- CNT_W, 20: counter width; must hold max(HOLD_TIME, COOLDOWN_TIME).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  unlock request; acts on its rising edge
- cancel  input  1  level; aborts an active hold
- door_open  input  1  door sensor, 1 = open
- unlock_out  output  1  actuator drive, 1 = unlocked
- busy  output  1  1 whenever state != IDLE
- done  output  1  one-cycle pulse when a hold completes normally
- remaining  output  CNT_W  hold cycles left (diagnostic/display)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, cnt = 0.
  - Edge register start_q = 1, so a start held high through reset does not trigger.
  - Outputs unlock_out = 0, busy = 0, done = 0, remaining = 0.
- Reset during any state returns to these values on the next edge.
- Edge detect: start_edge = start & ~start_q. start_q <= start every cycle.
- States: IDLE, HOLD, WAIT_CLOSE, COOLDOWN. All outputs are registered state/cnt decodes, with no combinational input-to-output path.
- IDLE:
  - start_edge & ~cancel -> HOLD, cnt <= 0.
  - cancel takes priority over start_edge in the same cycle.
- HOLD:
  - unlock_out = 1.
  - remaining = HOLD_TIME-1-cnt: HOLD_TIME-1 in the first cycle, 0 in the last.
  - Priority 1, cancel: -> COOLDOWN (or IDLE if COOLDOWN_TIME = 0), cnt <= 0, no done.
  - Priority 2, start_edge (retrigger): cnt <= 0, stay in HOLD, so unlock is extended.
  - Priority 3, cnt == HOLD_TIME-1:
    - Set done <= 1 for one cycle.
    - door_open = 1 -> WAIT_CLOSE.
    - Otherwise -> COOLDOWN (or IDLE if COOLDOWN_TIME = 0), cnt <= 0.
  - Otherwise cnt <= cnt+1.
- WAIT_CLOSE:
  - unlock_out = 0, remaining = 0.
  - start and cancel are ignored.
  - door_open = 0 -> COOLDOWN (or IDLE if COOLDOWN_TIME = 0), cnt <= 0.
- COOLDOWN:
  - unlock_out = 0, remaining = 0.
  - start edges and cancel are ignored; the edges are discarded, not queued.
  - cnt == COOLDOWN_TIME-1 -> IDLE; otherwise cnt <= cnt+1.
- Latency:
  - start_edge sampled at edge N -> unlock_out high for cycles N+1 .. N+HOLD_TIME (exactly HOLD_TIME cycles).
  - done high in cycle N+HOLD_TIME+1 only.
- Counter never wraps: every transition reloads it to 0, and it is compared with == against values below 2^CNT_W.

Test Plan:
(HOLD_TIME = 8, COOLDOWN_TIME = 3 in all scenarios; cycle k = state after edge k.)
1. Basic hold: reset cycles 0-2, start = 1 during cycle 10 only.
   -> unlock_out = 1 in cycles 11-18; remaining 7..0.
   -> done = 1 in cycle 19 only; busy = 1 in cycles 11-21; IDLE at 22.
2. Retrigger: as scenario 1 plus a second start pulse in cycle 15.
   -> unlock_out stays 1 through cycle 23; remaining jumps back to 7 in cycle 16.
   -> single done in cycle 24.
3. Cancel: as scenario 1 with cancel = 1 in cycle 14.
   -> unlock_out = 0 from cycle 15; no done pulse.
   -> COOLDOWN cycles 15-17; IDLE at 18.
   -> Same-cycle start + cancel in IDLE produces no trigger.
4. Door open: door_open = 1 from cycle 12, released in cycle 25.
   -> done in cycle 19; WAIT_CLOSE cycles 19-25 with unlock_out = 0, busy = 1.
   -> COOLDOWN 26-28; IDLE at 29.
5. Ignored starts:
   -> A start pulse in COOLDOWN or WAIT_CLOSE causes no new hold.
   -> start held high from before reset release through cycle 20 causes no hold.
   -> Releasing start then pulsing it triggers normally.
6. Reset mid-hold: reset = 1 in cycle 14.
   -> All outputs 0 in cycle 15 and remain IDLE with no done.
